// File: rtl/fish_game_pkg.sv
// Shared state encoding and finish-reason codes for the fishing-game flow controller.
package fish_game_pkg;

  typedef enum logic [4:0] {
    ST_START_MENU  = 5'b00001,
    ST_BASE_PLAY   = 5'b00010,
    ST_LINE_REEL   = 5'b00100,
    ST_PAUSED      = 5'b01000,
    ST_GAME_FINISH = 5'b10000
  } state_e;

  localparam logic [1:0] FR_NONE    = 2'd0;
  localparam logic [1:0] FR_QUIT    = 2'd1;
  localparam logic [1:0] FR_TIMEOUT = 2'd2;
  localparam logic [1:0] FR_ROUNDS  = 2'd3;

endpackage

// File: rtl/fish_countdown.sv
// Loadable down-counter that sticks at zero; load takes priority over decrement.
module fish_countdown #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec_en,
  output logic [WIDTH-1:0] count,
  output logic             is_zero
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec_en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count   = count_q;
  assign is_zero = (count_q == '0);

endmodule

// File: rtl/fish_gameflow_ctrl.sv
// Top-level game flow: menu, play, reel, pause and finish, with countdown timer,
// per-game attempt limit, catch scoring and a finish-reason code.
//
// state          | meaning
// ST_START_MENU  | idle, waiting for start; last game's results still shown
// ST_BASE_PLAY   | waiting for a bite, timer running
// ST_LINE_REEL   | fish on the line, timer running
// ST_PAUSED      | timer frozen, resumes to the state it was entered from
// ST_GAME_FINISH | results shown until start acknowledges
module fish_gameflow_ctrl
  import fish_game_pkg::*;
#(
  parameter int TIME_W     = 16,
  parameter int GAME_TIME  = 60,
  parameter int WARN_TIME  = 10,
  parameter int ROUND_W    = 4,
  parameter int MAX_ROUNDS = 10,
  parameter int CATCH_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               quit,
  input  logic               pause,
  input  logic               tick,
  input  logic               fish_hooked,
  input  logic               fish_caught,
  input  logic               fish_lost,
  output logic               q_start_menu,
  output logic               q_base_play,
  output logic               q_line_reel,
  output logic               q_paused,
  output logic               q_game_finish,
  output logic [TIME_W-1:0]  time_left,
  output logic [ROUND_W-1:0] rounds_left,
  output logic [CATCH_W-1:0] catch_count,
  output logic [1:0]         finish_reason,
  output logic               time_warn
);

  localparam logic [TIME_W-1:0]  GAME_TIME_L  = TIME_W'(GAME_TIME);
  localparam logic [TIME_W-1:0]  WARN_TIME_L  = TIME_W'(WARN_TIME);
  localparam logic [ROUND_W-1:0] MAX_ROUNDS_L = ROUND_W'(MAX_ROUNDS);

  state_e             state_q;
  logic               resume_reel_q;
  logic [ROUND_W-1:0] rounds_q;
  logic [CATCH_W-1:0] catch_q;
  logic [1:0]         reason_q;

  logic               timer_load;
  logic               timer_dec;
  logic               time_zero;
  logic [TIME_W-1:0]  time_q;

  assign timer_load = (state_q == ST_START_MENU) && start;
  // Decrement also lands on the edge that leaves for PAUSED or GAME_FINISH.
  assign timer_dec  = tick && ((state_q == ST_BASE_PLAY) || (state_q == ST_LINE_REEL));

  fish_countdown #(
    .WIDTH(TIME_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (timer_load),
    .load_val(GAME_TIME_L),
    .dec_en  (timer_dec),
    .count   (time_q),
    .is_zero (time_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_START_MENU;
      resume_reel_q <= 1'b0;
      rounds_q      <= '0;
      catch_q       <= '0;
      reason_q      <= FR_NONE;
    end else begin
      case (state_q)
        ST_START_MENU: begin
          if (start) begin
            state_q  <= ST_BASE_PLAY;
            rounds_q <= MAX_ROUNDS_L;
            catch_q  <= '0;
            reason_q <= FR_NONE;
          end
        end
        ST_BASE_PLAY: begin
          if (quit) begin
            state_q  <= ST_GAME_FINISH;
            reason_q <= FR_QUIT;
          end else if (pause) begin
            state_q       <= ST_PAUSED;
            resume_reel_q <= 1'b0;
          end else if (time_zero) begin
            state_q  <= ST_GAME_FINISH;
            reason_q <= FR_TIMEOUT;
          end else if (rounds_q == '0) begin
            state_q  <= ST_GAME_FINISH;
            reason_q <= FR_ROUNDS;
          end else if (fish_hooked) begin
            state_q <= ST_LINE_REEL;
          end
        end
        ST_LINE_REEL: begin
          if (quit) begin
            state_q  <= ST_GAME_FINISH;
            reason_q <= FR_QUIT;
          end else if (pause) begin
            state_q       <= ST_PAUSED;
            resume_reel_q <= 1'b1;
          end else if (time_zero) begin
            state_q  <= ST_GAME_FINISH;
            reason_q <= FR_TIMEOUT;
          end else if (fish_caught || fish_lost) begin
            state_q <= ST_BASE_PLAY;
            if (rounds_q != '0) rounds_q <= rounds_q - 1'b1;
            if (fish_caught && (catch_q != '1)) catch_q <= catch_q + 1'b1;
          end
        end
        ST_PAUSED: begin
          if (quit) begin
            state_q  <= ST_GAME_FINISH;
            reason_q <= FR_QUIT;
          end else if (pause) begin
            state_q <= resume_reel_q ? ST_LINE_REEL : ST_BASE_PLAY;
          end
        end
        ST_GAME_FINISH: begin
          if (start) state_q <= ST_START_MENU;
        end
        default: state_q <= ST_START_MENU;
      endcase
    end
  end

  assign q_start_menu  = (state_q == ST_START_MENU);
  assign q_base_play   = (state_q == ST_BASE_PLAY);
  assign q_line_reel   = (state_q == ST_LINE_REEL);
  assign q_paused      = (state_q == ST_PAUSED);
  assign q_game_finish = (state_q == ST_GAME_FINISH);

  assign time_left     = time_q;
  assign rounds_left   = rounds_q;
  assign catch_count   = catch_q;
  assign finish_reason = reason_q;
  assign time_warn     = !time_zero && (time_q <= WARN_TIME_L) &&
                         (q_base_play || q_line_reel || q_paused);

endmodule

// File: tb/tb_fish_gameflow_ctrl.sv
// Directed walk through the game flow followed by random stimulus, all checked
// cycle by cycle against a behavioural model of the game rules.
module tb_fish_gameflow_ctrl;

  localparam int GAME_TIME  = 60;
  localparam int WARN_TIME  = 10;
  localparam int MAX_ROUNDS = 10;
  localparam int CATCH_MAX  = 255;

  // model states
  localparam int MENU = 0, PLAY = 1, REEL = 2, PAUSE = 3, FIN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0, start = 1'b0, quit = 1'b0, pause = 1'b0, tick = 1'b0;
  logic        fish_hooked = 1'b0, fish_caught = 1'b0, fish_lost = 1'b0;
  logic        q_start_menu, q_base_play, q_line_reel, q_paused, q_game_finish;
  logic [15:0] time_left;
  logic [3:0]  rounds_left;
  logic [7:0]  catch_count;
  logic [1:0]  finish_reason;
  logic        time_warn;

  int n_checks = 0;
  int n_errors = 0;

  int m_st = MENU, m_time = 0, m_rounds = 0, m_catch = 0, m_reason = 0, m_resume = PLAY;

  fish_gameflow_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .quit         (quit),
    .pause        (pause),
    .tick         (tick),
    .fish_hooked  (fish_hooked),
    .fish_caught  (fish_caught),
    .fish_lost    (fish_lost),
    .q_start_menu (q_start_menu),
    .q_base_play  (q_base_play),
    .q_line_reel  (q_line_reel),
    .q_paused     (q_paused),
    .q_game_finish(q_game_finish),
    .time_left    (time_left),
    .rounds_left  (rounds_left),
    .catch_count  (catch_count),
    .finish_reason(finish_reason),
    .time_warn    (time_warn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, s, q, p, t, h, c, l);
    bit dec;
    int t_old;
    if (r) begin
      m_st = MENU; m_time = 0; m_rounds = 0; m_catch = 0; m_reason = 0; m_resume = PLAY;
      return;
    end
    t_old = m_time;
    dec = t && (m_st == PLAY || m_st == REEL);
    case (m_st)
      MENU: if (s) begin
        m_st = PLAY; m_time = GAME_TIME; m_rounds = MAX_ROUNDS; m_catch = 0; m_reason = 0;
      end
      PLAY: begin
        if (q) begin m_st = FIN; m_reason = 1; end
        else if (p) begin m_st = PAUSE; m_resume = PLAY; end
        else if (t_old == 0) begin m_st = FIN; m_reason = 2; end
        else if (m_rounds == 0) begin m_st = FIN; m_reason = 3; end
        else if (h) m_st = REEL;
      end
      REEL: begin
        if (q) begin m_st = FIN; m_reason = 1; end
        else if (p) begin m_st = PAUSE; m_resume = REEL; end
        else if (t_old == 0) begin m_st = FIN; m_reason = 2; end
        else if (c || l) begin
          m_st = PLAY;
          if (m_rounds > 0) m_rounds--;
          if (c && m_catch < CATCH_MAX) m_catch++;
        end
      end
      PAUSE: begin
        if (q) begin m_st = FIN; m_reason = 1; end
        else if (p) m_st = m_resume;
      end
      default: if (s) m_st = MENU;
    endcase
    if (dec && t_old > 0) m_time = t_old - 1;
  endtask

  task automatic compare_all();
    bit warn;
    warn = (m_time != 0) && (m_time <= WARN_TIME) && (m_st == PLAY || m_st == REEL || m_st == PAUSE);
    chk("q_start_menu",  32'(q_start_menu),  32'(m_st == MENU));
    chk("q_base_play",   32'(q_base_play),   32'(m_st == PLAY));
    chk("q_line_reel",   32'(q_line_reel),   32'(m_st == REEL));
    chk("q_paused",      32'(q_paused),      32'(m_st == PAUSE));
    chk("q_game_finish", 32'(q_game_finish), 32'(m_st == FIN));
    chk("time_left",     32'(time_left),     m_time);
    chk("rounds_left",   32'(rounds_left),   m_rounds);
    chk("catch_count",   32'(catch_count),   m_catch);
    chk("finish_reason", 32'(finish_reason), m_reason);
    chk("time_warn",     32'(time_warn),     32'(warn));
  endtask

  // inputs: rst start quit pause tick hooked caught lost
  task automatic cyc(input bit r, s, q, p, t, h, c, l);
    @(negedge clk);
    rst = r; start = s; quit = q; pause = p; tick = t;
    fish_hooked = h; fish_caught = c; fish_lost = l;
    @(posedge clk);
    model_step(r, s, q, p, t, h, c, l);
    #1;
    compare_all();
  endtask

  task automatic idle();    cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic go();      cyc(0, 1, 0, 0, 0, 0, 0, 0); endtask
  task automatic hook();    cyc(0, 0, 0, 0, 0, 1, 0, 0); endtask
  task automatic tk();      cyc(0, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic tgl();     cyc(0, 0, 0, 1, 0, 0, 0, 0); endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_menu", 32'(q_start_menu), 1);
    chk("rst_time", 32'(time_left), 0);

    go();
    chk("start_play", 32'(q_base_play), 1);
    chk("start_time", 32'(time_left), 60);
    chk("start_rounds", 32'(rounds_left), 10);
    chk("start_reason", 32'(finish_reason), 0);

    hook();
    chk("hook_reel", 32'(q_line_reel), 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    chk("catch1", 32'(catch_count), 1);
    chk("rounds9", 32'(rounds_left), 9);
    hook();
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk("catch2", 32'(catch_count), 2);
    chk("rounds8", 32'(rounds_left), 8);

    hook();
    tgl();
    for (int i = 0; i < 5; i++) begin
      tk();
      chk("pause_held", 32'(q_paused), 1);
    end
    chk("pause_frozen", 32'(time_left), 60);
    tgl();
    chk("resume_reel", 32'(q_line_reel), 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 60; i++) begin
      tk();
      if (i == 49) chk("warn_at10", 32'(time_warn), 1);
    end
    chk("time_zero", 32'(time_left), 0);
    chk("warn_drop", 32'(time_warn), 0);
    chk("still_play", 32'(q_base_play), 1);
    idle();
    chk("timeout_fin", 32'(q_game_finish), 1);
    chk("timeout_reason", 32'(finish_reason), 2);
    go();
    chk("back_menu", 32'(q_start_menu), 1);
    chk("catch_held", 32'(catch_count), 2);

    go();
    for (int i = 0; i < 10; i++) begin
      hook();
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
    end
    chk("rounds0", 32'(rounds_left), 0);
    idle();
    chk("rounds_reason", 32'(finish_reason), 3);

    go(); go(); tgl();
    cyc(0, 0, 1, 0, 0, 0, 0, 0);
    chk("quit_fin", 32'(q_game_finish), 1);
    chk("quit_reason", 32'(finish_reason), 1);

    go(); go(); hook();
    for (int i = 0; i < 52; i++) tk();
    chk("warn_mid", 32'(time_warn), 1);
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    chk("rst_mid_menu", 32'(q_start_menu), 1);
    chk("rst_mid_time", 32'(time_left), 0);
    chk("rst_mid_warn", 32'(time_warn), 0);

    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(199) == 0, $urandom_range(7) == 0, $urandom_range(39) == 0,
          $urandom_range(14) == 0, $urandom_range(2) == 0, $urandom_range(3) == 0,
          $urandom_range(5) == 0, $urandom_range(5) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fish_gameflow_ctrl.md
Name: fish_gameflow_ctrl

Overview:
Parametrised successor to the fishing-game top-level flow FSM. Adds pause/resume, a built-in countdown timer driven by a tick strobe, and a per-game limit on fish attempts. Also adds catch scoring, a finish-reason code and a restart path out of GAME_FINISH. Sits between the button debouncers/tick generator and the display/VGA logic, which consume its one-hot state and counters.

Parameters:
TIME_W, 16, width of time_left
GAME_TIME, 60, ticks loaded into timer at game start (1..2^TIME_W-1)
WARN_TIME, 10, time_warn asserted when 0 < time_left <= WARN_TIME
ROUND_W, 4, width of rounds_left
MAX_ROUNDS, 10, fish attempts per game (1..2^ROUND_W-1)
CATCH_W, 8, width of catch_count

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse: begin game / acknowledge finish
quit  in  1  single-cycle pulse: abort game
pause  in  1  single-cycle pulse: toggle pause
tick  in  1  single-cycle timebase strobe (e.g. 1 Hz)
fish_hooked  in  1  pulse from bite logic
fish_caught  in  1  pulse from reel logic
fish_lost  in  1  pulse from reel logic
q_start_menu, q_base_play, q_line_reel, q_paused, q_game_finish  out  1 each  one-hot state
time_left  out  TIME_W  remaining ticks
rounds_left  out  ROUND_W  remaining fish attempts
catch_count  out  CATCH_W  fish caught this game
finish_reason  out  2  0 none, 1 quit, 2 timeout, 3 rounds exhausted
time_warn  out  1  low-time indicator

Behaviour:
- Reset (sync, rst high at clk edge): state START_MENU; time_left=0; rounds_left=0; catch_count=0; finish_reason=0. Reset mid-game aborts immediately with no finish reason.
- All outputs are registered or decoded from registers. Each transition takes effect at the next clk edge. Counters and outputs update in the same edge as the transition.
- START_MENU: start -> BASE_PLAY. Same edge: time_left=GAME_TIME, rounds_left=MAX_ROUNDS, catch_count=0, finish_reason=0. All other inputs ignored.
- BASE_PLAY priority, highest first:
  - quit -> GAME_FINISH, reason 1.
  - pause -> PAUSED, resume target BASE_PLAY.
  - time_left==0 -> GAME_FINISH, reason 2.
  - rounds_left==0 -> GAME_FINISH, reason 3.
  - fish_hooked -> LINE_REEL.
  - Otherwise hold.
- LINE_REEL priority, highest first:
  - quit -> GAME_FINISH, reason 1.
  - pause -> PAUSED, resume target LINE_REEL.
  - time_left==0 -> GAME_FINISH, reason 2.
  - fish_caught -> BASE_PLAY, catch_count+1 (saturating at all-ones), rounds_left-1.
  - fish_lost -> BASE_PLAY, rounds_left-1.
  - caught and lost in the same cycle: caught wins.
  - fish_hooked ignored.
- PAUSED:
  - quit -> GAME_FINISH, reason 1.
  - pause -> stored resume target.
  - Timer frozen. tick, fish_* and start ignored.
- GAME_FINISH: start -> START_MENU. Counters and finish_reason hold until the next game start so the display can show results.
- Timer: on tick while state is BASE_PLAY or LINE_REEL, time_left decrements, saturating at 0. The decrement applies even on an edge where the state leaves due to pause or quit.
  - Timeout finish occurs one cycle after time_left reaches 0, because the comparison uses the registered value.
- rounds_left never underflows: a decrement at 0 is suppressed (unreachable by construction).
- time_warn = (time_left != 0) && (time_left <= WARN_TIME) && state is BASE_PLAY, LINE_REEL or PAUSED.
- Illegal state encoding: recover to START_MENU on the next edge. No X propagation.

Decomposition:
- Package fish_game_pkg holds:
  - one-hot state localparams ST_START_MENU=5'b00001, ST_BASE_PLAY=5'b00010, ST_LINE_REEL=5'b00100, ST_PAUSED=5'b01000, ST_GAME_FINISH=5'b10000;
  - finish-reason codes FR_NONE, FR_QUIT, FR_TIMEOUT, FR_ROUNDS.
- One sub-module, fish_countdown: a loadable saturating down-counter.
  - Parameter: width.
  - Inputs: clk, rst, load, load_val, dec_en.
  - Outputs: count, is_zero.
  - Instantiated for time_left.
- The round and catch counters stay inline.

Test Plan:
- Reset, then start pulse -> q_base_play=1, time_left=60, rounds_left=10, catch_count=0, finish_reason=0.
- fish_hooked, then fish_caught -> LINE_REEL, then BASE_PLAY; catch_count=1, rounds_left=9. Repeat with caught+lost in the same cycle -> catch_count=2, rounds_left=8.
- In LINE_REEL, pause, then 5 ticks, then pause -> q_paused during the ticks, time_left unchanged, resumes to q_line_reel.
- 60 ticks in BASE_PLAY -> time_left=0 and time_warn drops. One cycle later q_game_finish=1, finish_reason=2. Then start -> q_start_menu=1, catch_count still held.
- 10 hook/lost cycles -> rounds_left=0, next cycle GAME_FINISH with reason 3. In PAUSED, quit -> GAME_FINISH with reason 1.
- rst asserted mid-LINE_REEL with tick high -> next edge START_MENU, all counters 0, time_warn=0.
